// File: rtl/layer_operand_fetcher.sv
// Layer operand fetcher: walks a weight/input operand memory row by row, feeding a
// downstream element counter and waiting for its row-complete acknowledge.
module layer_operand_fetcher #(
  parameter int N_IN  = 3,
  parameter int N_OUT = 2,
  parameter int IW    = 2,
  parameter int WW    = 3,
  parameter int TMO   = 15,
  localparam int RW   = (N_OUT > 1) ? $clog2(N_OUT) : 1,
  localparam int TW   = $clog2(TMO + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stall,
  input  logic          ack_mac,
  output logic          rd_en,
  output logic [IW-1:0] in_addr,
  output logic [WW-1:0] w_addr,
  output logic          ack,
  output logic          cnt_rst,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [RW-1:0] row_idx
);

  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, WAIT_MAC, NEXT, FIN} state_t;

  state_t        state, state_nxt;
  logic [RW-1:0] row, row_nxt;
  logic [IW-1:0] col, col_nxt;
  logic [TW-1:0] wait_cnt, wait_nxt;
  logic          err_q, err_nxt;
  logic          ack_q;
  logic          fetch;

  // NOTE: every always_comb target gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    row_nxt   = row;
    col_nxt   = col;
    wait_nxt  = wait_cnt;
    err_nxt   = err_q;
    fetch     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = FETCH;
          row_nxt   = '0;
          col_nxt   = '0;
          err_nxt   = 1'b0;
        end
      end
      FETCH: begin
        if (!stall) begin
          fetch = 1'b1;
          if (col == IW'(N_IN - 1)) begin
            col_nxt   = '0;
            state_nxt = DRAIN;
          end else begin
            col_nxt = col + 1'b1;
          end
        end
      end
      DRAIN: begin
        wait_nxt  = '0;
        state_nxt = WAIT_MAC;
      end
      WAIT_MAC: begin
        if (ack_mac) begin
          state_nxt = NEXT;
        end else if (wait_cnt == TW'(TMO - 1)) begin
          err_nxt   = 1'b1;
          state_nxt = FIN;
        end else begin
          wait_nxt = wait_cnt + 1'b1;
        end
      end
      NEXT: begin
        if (row == RW'(N_OUT - 1)) begin
          state_nxt = FIN;
        end else begin
          row_nxt   = row + 1'b1;
          state_nxt = FETCH;
        end
      end
      FIN: begin
        row_nxt   = '0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(negedge clk) begin
    if (rst) begin
      state    <= IDLE;
      row      <= '0;
      col      <= '0;
      wait_cnt <= '0;
      err_q    <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      row      <= row_nxt;
      col      <= col_nxt;
      wait_cnt <= wait_nxt;
      err_q    <= err_nxt;
      ack_q    <= fetch;
    end
  end

  // Outputs are masked by rst so they read zero for the whole reset cycle, not just after the edge.
  assign rd_en   = fetch && !rst;
  assign in_addr = (state == FETCH && !rst) ? col : '0;
  assign w_addr  = (state == FETCH && !rst) ? WW'(32'(row) * N_IN + 32'(col)) : '0;
  assign ack     = ack_q && !rst;
  assign cnt_rst = (state == NEXT) && !rst;
  assign busy    = !rst && (state inside {FETCH, DRAIN, WAIT_MAC, NEXT});
  assign done    = (state == FIN) && !rst;
  assign err     = err_q && !rst;
  assign row_idx = rst ? '0 : row;

endmodule
